projectile_pool: RTL and testbench

PROJECTILE_POOL -- requirements
Module: projectile_pool

---
 rtl/projectile_pool.sv | 184 ++++++++++++++++++
 tb/tb_projectile_pool.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool.sv
`default_nettype none
// ============================================================================
// Module      : projectile_pool
// Description : Pool of NUM_SLOTS independent projectiles. A debounced-edge
//               fire request spawns a projectile in the lowest free slot at
//               the bird position plus an x offset. The projectile then moves
//               right by STEP on every shared divider tick. It is freed when
//               it reaches the right screen edge, or on a collision, which
//               raises a one-cycle hit pulse. Ammo, refill and an optional
//               fire cooldown gate the spawns.
// Ports       : clk, reset (sync, active-high), restart (sync clear),
//               shootN (raw active-low button), refill (pulse),
//               bird_x/bird_y (spawn reference), collision[NUM_SLOTS]
//               -> in_air, pos_x/pos_y (packed per slot), ammo,
//                  hit_pulse, fire_reject  (all registered)
// Revision    : 1.0  initial release
// ============================================================================
module projectile_pool #(
  parameter int NUM_SLOTS   = 3,
  parameter int COORD_W     = 11,
  parameter int AMMO_W      = 4,
  parameter int MAX_AMMO    = 3,
  parameter int SPEED_DIV   = 60000,
  parameter int STEP        = 1,
  parameter int SCREEN_W    = 640,
  parameter int SPAWN_OFS_X = 100,
  parameter int COOLDOWN    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           restart,
  input  logic                           shootN,
  input  logic                           refill,
  input  logic [COORD_W-1:0]             bird_x,
  input  logic [COORD_W-1:0]             bird_y,
  input  logic [NUM_SLOTS-1:0]           collision,
  output logic [NUM_SLOTS-1:0]           in_air,
  output logic [NUM_SLOTS*COORD_W-1:0]   pos_x,
  output logic [NUM_SLOTS*COORD_W-1:0]   pos_y,
  output logic [AMMO_W-1:0]              ammo,
  output logic [NUM_SLOTS-1:0]           hit_pulse,
  output logic                           fire_reject
);

  localparam int c_DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int c_CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  typedef enum logic {
    S_FREE   = 1'b0,
    S_FLYING = 1'b1
  } slot_state_t;

  logic                 w_clr;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync_prev;
  logic                 w_fire_req;
  logic [c_DIV_W-1:0]   r_div;
  logic                 w_tick;
  logic [c_CD_W-1:0]    r_cd;
  logic [AMMO_W-1:0]    r_ammo;
  logic                 r_reject;
  logic [NUM_SLOTS-1:0] w_alloc;
  logic                 w_slot_found;
  logic                 w_accept;
  logic [COORD_W-1:0]   w_spawn_x;

  assign w_clr = reset | restart;

  // Falling edge of the synchronised button; a held button stays low in
  // both stages and therefore yields a single request.
  assign w_fire_req = r_sync_prev & ~r_sync2;

  assign w_tick    = (r_div == c_DIV_W'(SPEED_DIV - 1));
  assign w_spawn_x = bird_x + COORD_W'(SPAWN_OFS_X);

  // Lowest-index free slot, judged on the mask held at the start of the
  // cycle so a slot released this cycle is only reusable next cycle.
  always_comb begin
    w_alloc      = '0;
    w_slot_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!w_slot_found && !in_air[i]) begin
        w_alloc[i]   = 1'b1;
        w_slot_found = 1'b1;
      end
    end
  end

  assign w_accept = w_fire_req && (r_ammo != '0) && (r_cd == '0) && w_slot_found;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
      r_div       <= '0;
      r_cd        <= '0;
      r_ammo      <= AMMO_W'(MAX_AMMO);
      r_reject    <= 1'b0;
    end else begin
      r_sync1     <= shootN;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;

      // Free-running shared movement divider.
      if (w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + c_DIV_W'(1);
      end

      if (w_accept) begin
        r_cd <= c_CD_W'(COOLDOWN);
      end else if (r_cd != '0) begin
        r_cd <= r_cd - c_CD_W'(1);
      end

      // A refill coinciding with an accepted shot still spends that shot.
      if (refill) begin
        r_ammo <= w_accept ? AMMO_W'(MAX_AMMO - 1) : AMMO_W'(MAX_AMMO);
      end else if (w_accept) begin
        r_ammo <= r_ammo - AMMO_W'(1);
      end

      r_reject <= w_fire_req & ~w_accept;
    end
  end

  assign ammo        = r_ammo;
  assign fire_reject = r_reject;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    slot_state_t        r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_hit;
    logic [COORD_W:0]   w_x_adv;

    // One extra bit so the edge compare cannot wrap near the top of range.
    assign w_x_adv = {1'b0, r_x} + (COORD_W + 1)'(STEP);

    always_ff @(posedge clk) begin
      if (w_clr) begin
        r_state <= S_FREE;
        r_x     <= '0;
        r_y     <= '0;
        r_hit   <= 1'b0;
      end else begin
        r_hit <= 1'b0;
        case (r_state)
          S_FREE: begin
            // Collisions are ignored here; position is held.
            if (w_accept && w_alloc[gi]) begin
              r_x     <= w_spawn_x;
              r_y     <= bird_y;
              r_state <= S_FLYING;
            end
          end
          S_FLYING: begin
            // Collision wins over movement.
            if (collision[gi]) begin
              r_state <= S_FREE;
              r_hit   <= 1'b1;
            end else if (w_tick) begin
              if (w_x_adv < (COORD_W + 1)'(SCREEN_W)) begin
                r_x <= w_x_adv[COORD_W-1:0];
              end else begin
                r_state <= S_FREE;
              end
            end
          end
        endcase
      end
    end

    assign in_air[gi]                       = (r_state == S_FLYING);
    assign hit_pulse[gi]                    = r_hit;
    assign pos_x[gi*COORD_W +: COORD_W]     = r_x;
    assign pos_y[gi*COORD_W +: COORD_W]     = r_y;
  end

endmodule
`default_nettype wire

// File: tb/tb_projectile_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_projectile_pool
// Description : Directed self-checking bench for projectile_pool. A main
//               instance (COOLDOWN=0) covers flight, edge exit, allocation,
//               rejection, collision, refill and reset/restart. A second
//               instance (COOLDOWN=5) covers the fire cooldown.
// Revision    : 1.0  initial release
// ============================================================================
module tb_projectile_pool;

  localparam int c_NS = 3;
  localparam int c_CW = 11;
  localparam int c_AW = 4;

  logic                 clk;
  logic                 reset;
  logic                 restart;
  logic                 shootN;
  logic                 refill;
  logic [c_CW-1:0]      bird_x;
  logic [c_CW-1:0]      bird_y;
  logic [c_NS-1:0]      collision;
  logic [c_NS-1:0]      in_air;
  logic [c_NS*c_CW-1:0] pos_x;
  logic [c_NS*c_CW-1:0] pos_y;
  logic [c_AW-1:0]      ammo;
  logic [c_NS-1:0]      hit_pulse;
  logic                 fire_reject;

  logic                 shootN2;
  logic [c_NS-1:0]      in_air2;
  logic [c_NS*c_CW-1:0] pos_x2;
  logic [c_NS*c_CW-1:0] pos_y2;
  logic [c_AW-1:0]      ammo2;
  logic [c_NS-1:0]      hit_pulse2;
  logic                 fire_reject2;

  int n_total;
  int n_pass;
  int n_fail;

  projectile_pool #(
    .NUM_SLOTS(3), .COORD_W(11), .AMMO_W(4), .MAX_AMMO(3), .SPEED_DIV(4),
    .STEP(1), .SCREEN_W(20), .SPAWN_OFS_X(5), .COOLDOWN(0)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .shootN(shootN),
    .refill(refill), .bird_x(bird_x), .bird_y(bird_y), .collision(collision),
    .in_air(in_air), .pos_x(pos_x), .pos_y(pos_y), .ammo(ammo),
    .hit_pulse(hit_pulse), .fire_reject(fire_reject)
  );

  projectile_pool #(
    .NUM_SLOTS(3), .COORD_W(11), .AMMO_W(4), .MAX_AMMO(3), .SPEED_DIV(4),
    .STEP(1), .SCREEN_W(20), .SPAWN_OFS_X(5), .COOLDOWN(5)
  ) dut_cd (
    .clk(clk), .reset(reset), .restart(1'b0), .shootN(shootN2),
    .refill(1'b0), .bird_x(bird_x), .bird_y(bird_y), .collision(3'b000),
    .in_air(in_air2), .pos_x(pos_x2), .pos_y(pos_y2), .ammo(ammo2),
    .hit_pulse(hit_pulse2), .fire_reject(fire_reject2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Button high for 3 cycles, then pressed; returns on the cycle the
  // resulting spawn or reject is visible, with the button released.
  task automatic press();
    shootN = 1'b1;
    step(3);
    shootN = 1'b0;
    step(3);
    shootN = 1'b1;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    n_fail    = 0;
    reset     = 1'b1;
    restart   = 1'b0;
    shootN    = 1'b1;
    shootN2   = 1'b1;
    refill    = 1'b0;
    collision = '0;
    bird_x    = 11'd2;
    bird_y    = 11'd7;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_in_air", in_air, 3'b000);
    check("rst_ammo", ammo, 4'd3);
    check("rst_pos_x", pos_x, 33'd0);
    check("rst_pos_y", pos_y, 33'd0);
    check("rst_hit", hit_pulse, 3'b000);
    check("rst_reject", fire_reject, 1'b0);

    // Single flight from (7,7) to the right edge
    press();
    check("fly_in_air", in_air, 3'b001);
    check("fly_x0", pos_x[10:0], 11'd7);
    check("fly_y0", pos_y[10:0], 11'd7);
    check("fly_ammo", ammo, 4'd2);
    step(1);
    check("fly_x_hold", pos_x[10:0], 11'd7);
    step(1);
    check("fly_x_tick1", pos_x[10:0], 11'd8);
    step(4);
    check("fly_x_tick2", pos_x[10:0], 11'd9);
    step(40);
    check("fly_x_19", pos_x[10:0], 11'd19);
    step(3);
    check("fly_still_air", in_air, 3'b001);
    step(1);
    check("edge_freed", in_air, 3'b000);
    check("edge_x_held", pos_x[10:0], 11'd19);
    check("edge_no_hit", hit_pulse, 3'b000);

    // Refill then four presses: three spawns and a reject
    refill = 1'b1;
    step(1);
    refill = 1'b0;
    check("refill_ammo", ammo, 4'd3);
    press();
    check("p1_in_air", in_air, 3'b001);
    check("p1_ammo", ammo, 4'd2);
    press();
    check("p2_in_air", in_air, 3'b011);
    check("p2_ammo", ammo, 4'd1);
    press();
    check("p3_in_air", in_air, 3'b111);
    check("p3_ammo", ammo, 4'd0);
    press();
    check("p4_reject", fire_reject, 1'b1);
    check("p4_in_air", in_air, 3'b111);
    check("p4_ammo", ammo, 4'd0);
    step(1);
    check("p4_reject_pulse", fire_reject, 1'b0);

    // Collision on slot 1, then re-allocation of slot 1
    collision = 3'b010;
    step(1);
    collision = 3'b000;
    check("coll_in_air", in_air, 3'b101);
    check("coll_hit", hit_pulse, 3'b010);
    step(1);
    check("coll_hit_pulse", hit_pulse, 3'b000);
    refill = 1'b1;
    step(1);
    refill = 1'b0;
    bird_x = 11'd10;
    bird_y = 11'd3;
    press();
    check("realloc_in_air", in_air, 3'b111);
    check("realloc_x1", pos_x[21:11], 11'd15);
    check("realloc_y1", pos_y[21:11], 11'd3);
    check("realloc_ammo", ammo, 4'd2);

    // Reset mid-flight
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_in_air", in_air, 3'b000);
    check("midrst_pos_x", pos_x, 33'd0);
    check("midrst_pos_y", pos_y, 33'd0);
    check("midrst_ammo", ammo, 4'd3);
    check("midrst_hit", hit_pulse, 3'b000);

    // Restart mid-flight
    press();
    press();
    check("pre_restart_air", in_air, 3'b011);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_in_air", in_air, 3'b000);
    check("restart_pos_x", pos_x, 33'd0);
    check("restart_pos_y", pos_y, 33'd0);
    check("restart_ammo", ammo, 4'd3);
    check("restart_hit", hit_pulse, 3'b000);

    // Held button fires once
    bird_x = 11'd0;
    bird_y = 11'd0;
    step(3);
    shootN = 1'b0;
    step(3);
    check("hold_spawn", in_air, 3'b001);
    check("hold_ammo1", ammo, 4'd2);
    step(97);
    shootN = 1'b1;
    check("hold_ammo2", ammo, 4'd2);
    check("hold_in_air", in_air, 3'b000);
    step(3);

    // Refill coinciding with an accepted fire
    shootN = 1'b0;
    step(2);
    refill = 1'b1;
    step(1);
    refill = 1'b0;
    shootN = 1'b1;
    check("refill_fire_ammo", ammo, 4'd2);
    check("refill_fire_air", in_air, 3'b001);
    check("refill_fire_rej", fire_reject, 1'b0);

    // Collision on a free slot is ignored
    collision = 3'b100;
    step(1);
    collision = 3'b000;
    check("free_coll_hit", hit_pulse, 3'b000);
    check("free_coll_air", in_air, 3'b001);

    // Cooldown: second press 3 cycles later is refused, later one accepted
    shootN2 = 1'b0;
    step(3);
    check("cd_first_air", in_air2, 3'b001);
    check("cd_first_ammo", ammo2, 4'd2);
    shootN2 = 1'b1;
    step(1);
    shootN2 = 1'b0;
    step(3);
    check("cd_reject", fire_reject2, 1'b1);
    check("cd_reject_ammo", ammo2, 4'd2);
    check("cd_reject_air", in_air2, 3'b001);
    shootN2 = 1'b1;
    step(6);
    shootN2 = 1'b0;
    step(3);
    shootN2 = 1'b1;
    check("cd_after_air", in_air2, 3'b011);
    check("cd_after_ammo", ammo2, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
